fpdiv_issue: RTL and testbench
==============================

FPDIV_ISSUE -- requirements
Module: fpdiv_issue

Interface
REQ-001 SHALL have parameter DEPTH, 4, operand FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter START_CYC, 2, cycles div_start is held high per operation.
REQ-003 SHALL have parameter TIMEOUT, 32, WAIT-state cycle limit, used only under FPDIV_ISSUE_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have in_valid (input, 1), in_ready (output, 1): request handshake, transfer when both high at clk rise.
REQ-007 SHALL have in_op1 and in_op2 (input, 64 each): double-format operands; in_rm (input, 3); in_op_type, in_P, in_OvEn, in_UnEn (input, 1 each).
REQ-008 SHALL have div_start (output, 1), div_op1 and div_op2 (output, 64 each), div_rm (output, 3), div_op_type, div_P, div_OvEn, div_UnEn (output, 1 each): drive the fpdiv block.
REQ-009 SHALL have div_done (input, 1), div_result (input, 64), div_flags (input, 5), div_denorm (input, 1): results returned by fpdiv.
REQ-010 SHALL have out_valid (output, 1), out_ready (input, 1), out_result (output, 64), out_flags (output, 5), out_denorm (output, 1), out_timeout (output, 1): result handshake and payload.
REQ-011 SHALL have busy (output, 1), high whenever the state is not IDLE or the FIFO is non-empty.

Function
REQ-012 SHALL buffer accepted requests in a DEPTH-entry FIFO; in_ready = not full, with no bypass, so a push while full is impossible.
REQ-013 SHALL issue requests in strict acceptance order through the states IDLE, START, WAIT and DRAIN.
REQ-014 SHALL, in IDLE with the FIFO non-empty, pop the head into the div_* operand registers and enter START at the same edge.
REQ-015 SHALL hold div_start=1 for exactly START_CYC cycles in START, then enter WAIT with div_start=0.
REQ-016 SHALL hold the div_* operands stable from entry into START until the exit from WAIT.
REQ-017 SHALL ignore div_done while in IDLE, START or DRAIN.
REQ-018 SHALL, on the first WAIT cycle with div_done=1, capture div_result, div_flags and div_denorm into the out_* registers, set out_valid=1 and out_timeout=0, and enter DRAIN.
REQ-019 SHALL, in DRAIN, hold out_* stable until out_valid and out_ready are both high, then clear out_valid and return to IDLE at that edge.
REQ-020 SHALL give a minimum latency from push edge k to the first div_start=1 cycle of one cycle, with div_start high from edge k+1 to edge k+1+START_CYC.
REQ-021 SHALL allow an in_valid push in any state, including the same edge as a pop.
REQ-022 SHALL allow an out_ready pulse outside DRAIN, which has no effect.

Reset
REQ-023 SHALL, on reset=1 regardless of clk, force state IDLE, an empty FIFO, div_start=0, div_* operands 0, out_valid=0, out_result=0, out_flags=0, out_denorm=0, out_timeout=0, in_ready=1 and busy=0.
REQ-024 SHALL discard any in-flight operation when reset is asserted mid-operation, with no result produced.

Configuration
REQ-025 SHALL, with FPDIV_ISSUE_TIMEOUT_EN defined, count WAIT cycles and, if TIMEOUT cycles elapse without div_done, load out_result=64'h7FF8000000000000, out_flags=5'b00000, out_denorm=0 and out_timeout=1, then enter DRAIN.
REQ-026 SHALL, with FPDIV_ISSUE_TIMEOUT_EN defined, ignore a div_done that arrives after a timeout until the next WAIT.
REQ-027 SHALL, without FPDIV_ISSUE_TIMEOUT_EN, wait indefinitely in WAIT, tie out_timeout to 0 and omit the counter.

Verification
REQ-028 SHALL cover this single divide: push op1=3FF8000000000000 and op2=4000000000000000; div_start is high for 2 cycles; drive div_done with div_result=3FE8000000000000 and flags 0. Required: out_valid=1 with matching payload and out_timeout=0.
REQ-029 SHALL cover back-pressure: push 5 requests with out_ready=0 and DEPTH=4. Required: in_ready goes low after the 4th FIFO entry, and the 5th is accepted only after the first result drains, with results in push order.
REQ-030 SHALL cover spurious done: assert div_done during START and during DRAIN. Required: no capture, and out_result is unchanged.
REQ-031 SHALL cover reset mid-operation: assert reset in WAIT with 2 entries queued. Required: everything returns to its reset value immediately, and no out_valid is seen afterwards.
REQ-032 SHALL cover timeout (macro defined): withhold div_done for 32 WAIT cycles. Required: out_result=7FF8000000000000 and out_timeout=1; a later div_done is ignored.
REQ-033 SHALL cover same-edge push and pop: push while IDLE pops. Required: no loss or duplication, and the FIFO count is unchanged.

Source files
------------

// File: rtl/fpdiv_issue.sv
// fpdiv_issue: in-order operand FIFO feeding one fpdiv unit, with a held start and a registered result stage.
// Defining FPDIV_ISSUE_TIMEOUT_EN adds a WAIT-state watchdog that returns a quiet NaN after TIMEOUT cycles.

module fpdiv_issue #(
  parameter int DEPTH     = 4,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 32
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_op1,
  input  logic [63:0] in_op2,
  input  logic [2:0]  in_rm,
  input  logic        in_op_type,
  input  logic        in_P,
  input  logic        in_OvEn,
  input  logic        in_UnEn,

  output logic        div_start,
  output logic [63:0] div_op1,
  output logic [63:0] div_op2,
  output logic [2:0]  div_rm,
  output logic        div_op_type,
  output logic        div_P,
  output logic        div_OvEn,
  output logic        div_UnEn,

  input  logic        div_done,
  input  logic [63:0] div_result,
  input  logic [4:0]  div_flags,
  input  logic        div_denorm,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_flags,
  output logic        out_denorm,
  output logic        out_timeout,

  output logic        busy
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SCW-1:0] START_LAST = SCW'(START_CYC - 1);

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic        op_type;
    logic        p;
    logic        ov_en;
    logic        un_en;
  } req_t;

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

  state_t         state_q, state_d;
  req_t           fifo_q [DEPTH];
  req_t           fifo_d [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  req_t           op_q, op_d;
  req_t           in_req;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [63:0]    out_result_q, out_result_d;
  logic [4:0]     out_flags_q, out_flags_d;
  logic           out_denorm_q, out_denorm_d;
  logic           fifo_full, fifo_empty, push, pop;

`ifdef FPDIV_ISSUE_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  logic [TCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           out_timeout_q, out_timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

  assign in_req     = {in_op1, in_op2, in_rm, in_op_type, in_P, in_OvEn, in_UnEn};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // No bypass: a pop in the same cycle does not free a slot for a full FIFO.
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = in_req;
      wr_ptr_d                 = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    start_cnt_d  = start_cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_denorm_d = out_denorm_q;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    out_timeout_d = out_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          op_d        = fifo_q[rd_ptr_q[AW-1:0]];
          start_cnt_d = '0;
          state_d     = START;
        end
      end
      START: begin
        if (start_cnt_q == START_LAST) begin
          state_d = WAIT;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          start_cnt_d = start_cnt_q + SCW'(1);
        end
      end
      WAIT: begin
        // A done on the watchdog's final cycle still wins over the timeout.
        if (div_done) begin
          out_result_d = div_result;
          out_flags_d  = div_flags;
          out_denorm_d = div_denorm;
          out_valid_d  = 1'b1;
          state_d      = DRAIN;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
          out_timeout_d = 1'b0;
        end else if (wait_cnt_q == TO_LAST) begin
          out_result_d  = 64'h7FF8000000000000;
          out_flags_d   = 5'b00000;
          out_denorm_d  = 1'b0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = DRAIN;
        end else begin
          wait_cnt_d = wait_cnt_q + TCW'(1);
`endif
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      op_q         <= '0;
      start_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_denorm_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
`ifdef FPDIV_ISSUE_TIMEOUT_EN
      wait_cnt_q    <= '0;
      out_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      op_q         <= op_d;
      start_cnt_q  <= start_cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_denorm_q <= out_denorm_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
`ifdef FPDIV_ISSUE_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      out_timeout_q <= out_timeout_d;
`endif
    end
  end

  assign in_ready    = !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign div_start   = (state_q == START);
  assign div_op1     = op_q.op1;
  assign div_op2     = op_q.op2;
  assign div_rm      = op_q.rm;
  assign div_op_type = op_q.op_type;
  assign div_P       = op_q.p;
  assign div_OvEn    = op_q.ov_en;
  assign div_UnEn    = op_q.un_en;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign out_denorm  = out_denorm_q;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
  assign out_timeout = out_timeout_q;
`else
  assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpdiv_issue.sv
// tb_fpdiv_issue: directed/randomized bench for fpdiv_issue; the bench itself plays the fpdiv unit
// and keeps an in-order queue of accepted requests as the reference model.

module tb_fpdiv_issue;

  localparam int DEPTH     = 4;
  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 32;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic        op_type;
    logic        p;
    logic        ov_en;
    logic        un_en;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_op1, in_op2;
  logic [2:0]  in_rm;
  logic        in_op_type, in_P, in_OvEn, in_UnEn;
  logic        div_start;
  logic [63:0] div_op1, div_op2;
  logic [2:0]  div_rm;
  logic        div_op_type, div_P, div_OvEn, div_UnEn;
  logic        div_done;
  logic [63:0] div_result;
  logic [4:0]  div_flags;
  logic        div_denorm;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_flags;
  logic        out_denorm, out_timeout;
  logic        busy;
  req_t        div_obs;

  req_t model_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  fpdiv_issue #(.DEPTH(DEPTH), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_rm(in_rm),
    .in_op_type(in_op_type), .in_P(in_P), .in_OvEn(in_OvEn), .in_UnEn(in_UnEn),
    .div_start(div_start), .div_op1(div_op1), .div_op2(div_op2), .div_rm(div_rm),
    .div_op_type(div_op_type), .div_P(div_P), .div_OvEn(div_OvEn), .div_UnEn(div_UnEn),
    .div_done(div_done), .div_result(div_result), .div_flags(div_flags), .div_denorm(div_denorm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_denorm(out_denorm), .out_timeout(out_timeout),
    .busy(busy)
  );

  assign div_obs = {div_op1, div_op2, div_rm, div_op_type, div_P, div_OvEn, div_UnEn};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkReq(input string tag, input req_t obs, input req_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t randReq();
    req_t r;
    r.op1     = {$urandom, $urandom};
    r.op2     = {$urandom, $urandom};
    r.rm      = 3'($urandom_range(0, 7));
    r.op_type = 1'($urandom_range(0, 1));
    r.p       = 1'($urandom_range(0, 1));
    r.ov_en   = 1'($urandom_range(0, 1));
    r.un_en   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic applyStimulus(input req_t r);
    in_op1     = r.op1;
    in_op2     = r.op2;
    in_rm      = r.rm;
    in_op_type = r.op_type;
    in_P       = r.p;
    in_OvEn    = r.ov_en;
    in_UnEn    = r.un_en;
    in_valid   = 1'b1;
  endtask

  // Holds the request until the handshake completes, then records it in the model.
  task automatic pushOne(input req_t r);
    int guard;
    applyStimulus(r);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready) begin
      model_q.push_back(r);
      @(negedge clk);
    end else begin
      checkBit("push_bound", in_ready, 1'b1);
    end
    in_valid = 1'b0;
  endtask

  // Plays fpdiv for the oldest outstanding request and checks the result stage.
  task automatic runOp(input logic [63:0] res, input logic [4:0] fl, input logic den,
                       input int delay, input bit chk_len, input bit spurious, input bit do_drain);
    req_t exp;
    int   n;
    int   guard;
    exp = model_q.pop_front();
    if (chk_len) begin
      guard = 0;
      while (!div_start && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      checkBit("start_seen", div_start, 1'b1);
    end
    n = 0;
    while (div_start && n < START_CYC + 4) begin
      checkReq("start_ops", div_obs, exp);
      if (spurious && n == 0) begin
        div_done   = 1'b1;
        div_result = ~res;
        div_flags  = 5'h1f;
      end
      @(negedge clk);
      div_done = 1'b0;
      n++;
    end
    if (chk_len) checkWord("start_len", 64'(n), 64'(START_CYC));
    for (int i = 0; i < delay; i++) begin
      checkBit("wait_no_valid", out_valid, 1'b0);
      checkBit("wait_no_start", div_start, 1'b0);
      checkReq("wait_ops", div_obs, exp);
      @(negedge clk);
    end
    div_done   = 1'b1;
    div_result = res;
    div_flags  = fl;
    div_denorm = den;
    @(negedge clk);
    div_done   = 1'b0;
    div_result = {$urandom, $urandom};
    div_flags  = ~fl;
    div_denorm = ~den;
    checkBit("out_valid", out_valid, 1'b1);
    checkWord("out_result", out_result, res);
    checkWord("out_flags", 64'(out_flags), 64'(fl));
    checkBit("out_denorm", out_denorm, den);
    checkBit("out_timeout", out_timeout, 1'b0);
    if (spurious) begin
      div_done   = 1'b1;
      div_result = ~res;
      @(negedge clk);
      div_done = 1'b0;
      checkWord("drain_hold", out_result, res);
      checkBit("drain_valid", out_valid, 1'b1);
    end
    if (do_drain) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkBit("drained", out_valid, 1'b0);
    end
  endtask

  initial begin
    req_t        r, r5, rd;
    req_t        zero_req;
    logic [63:0] res0;
    int          guard;

    zero_req   = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_op1     = '0;
    in_op2     = '0;
    in_rm      = '0;
    in_op_type = 1'b0;
    in_P       = 1'b0;
    in_OvEn    = 1'b0;
    in_UnEn    = 1'b0;
    div_done   = 1'b0;
    div_result = '0;
    div_flags  = '0;
    div_denorm = 1'b0;
    out_ready  = 1'b0;

    // Reset state, observed before any clock edge.
    #1;
    checkBit("rst_in_ready", in_ready, 1'b1);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_div_start", div_start, 1'b0);
    checkReq("rst_div_ops", div_obs, zero_req);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkWord("rst_out_result", out_result, 64'h0);
    checkWord("rst_out_flags", 64'(out_flags), 64'h0);
    checkBit("rst_out_timeout", out_timeout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single known divide with one-cycle push-to-start latency.
    $display("[TB] single divide");
    r = '0;
    r.op1 = 64'h3FF8000000000000;
    r.op2 = 64'h4000000000000000;
    pushOne(r);
    checkBit("latency_idle", div_start, 1'b0);
    checkBit("latency_busy", busy, 1'b1);
    @(negedge clk);
    checkBit("latency_start", div_start, 1'b1);
    runOp(64'h3FE8000000000000, 5'b00000, 1'b0, 3, 1'b1, 1'b0, 1'b1);

    // Random operands, random done delay; one pass includes spurious dones.
    $display("[TB] random ops");
    for (int k = 0; k < 5; k++) begin
      pushOne(randReq());
      runOp({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 4)), 1'b1, (k == 1), 1'b1);
    end

    // Back-pressure: a result stuck in DRAIN stops pops, so the FIFO fills.
    $display("[TB] back-pressure");
    pushOne(randReq());
    res0 = {$urandom, $urandom};
    runOp(res0, 5'h3, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      checkBit("bp_ready", in_ready, 1'b1);
      pushOne(randReq());
    end
    checkBit("bp_full", in_ready, 1'b0);
    r5 = randReq();
    applyStimulus(r5);
    for (int i = 0; i < 4; i++) begin
      checkBit("bp_blocked", in_ready, 1'b0);
      checkWord("bp_hold", out_result, res0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkBit("bp_drained", out_valid, 1'b0);
    checkBit("bp_still_full", in_ready, 1'b0);
    pushOne(r5);
    runOp({$urandom, $urandom}, 5'h1, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      runOp({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'b1,
            int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
    end
    checkBit("bp_idle", busy, 1'b0);

    // Same-edge push and pop with two entries queued.
    $display("[TB] same-edge push/pop");
    pushOne(randReq());
    runOp({$urandom, $urandom}, 5'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    pushOne(randReq());
    pushOne(randReq());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rd = randReq();
    applyStimulus(rd);
    checkBit("se_ready", in_ready, 1'b1);
    model_q.push_back(rd);
    @(negedge clk);
    in_valid = 1'b0;
    checkBit("se_pop", div_start, 1'b1);
    checkReq("se_pop_ops", div_obs, model_q[0]);
    pushOne(randReq());
    pushOne(randReq());
    checkBit("se_full", in_ready, 1'b0);
    runOp({$urandom, $urandom}, 5'h2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      runOp({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'b0,
            int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b1);
    end
    checkBit("se_idle", busy, 1'b0);

`ifdef FPDIV_ISSUE_TIMEOUT_EN
    // Watchdog: no done for TIMEOUT WAIT cycles gives a quiet NaN; late done ignored.
    $display("[TB] timeout");
    pushOne(randReq());
    void'(model_q.pop_front());
    guard = 0;
    while (!div_start && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (div_start && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < TIMEOUT; i++) begin
      checkBit("to_wait", out_valid, 1'b0);
      @(negedge clk);
    end
    checkBit("to_valid", out_valid, 1'b1);
    checkWord("to_result", out_result, QNAN);
    checkBit("to_flag", out_timeout, 1'b1);
    checkWord("to_flags", 64'(out_flags), 64'h0);
    checkBit("to_denorm", out_denorm, 1'b0);
    div_done   = 1'b1;
    div_result = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkWord("to_late_result", out_result, QNAN);
      checkBit("to_late_flag", out_timeout, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    div_done = 1'b0;
    checkBit("to_after_valid", out_valid, 1'b0);
    checkBit("to_after_busy", busy, 1'b0);
    pushOne(randReq());
    runOp({$urandom, $urandom}, 5'h4, 1'b0, 1, 1'b1, 1'b0, 1'b1);
`else
    // Without the watchdog a long wait must not produce a result early.
    $display("[TB] long wait");
    pushOne(randReq());
    runOp({$urandom, $urandom}, 5'h4, 1'b0, TIMEOUT + 8, 1'b1, 1'b0, 1'b1);
`endif

    // Reset in WAIT with two requests queued.
    $display("[TB] reset mid-operation");
    pushOne(randReq());
    pushOne(randReq());
    pushOne(randReq());
    guard = 0;
    while (!div_start && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (div_start && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkBit("mid_busy", busy, 1'b1);
    checkBit("mid_in_wait", div_start, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkBit("mid_rst_ready", in_ready, 1'b1);
    checkBit("mid_rst_busy", busy, 1'b0);
    checkBit("mid_rst_start", div_start, 1'b0);
    checkReq("mid_rst_ops", div_obs, zero_req);
    checkBit("mid_rst_valid", out_valid, 1'b0);
    checkWord("mid_rst_result", out_result, 64'h0);
    checkBit("mid_rst_timeout", out_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    div_done   = 1'b1;
    div_result = {$urandom, $urandom};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkBit("post_rst_valid", out_valid, 1'b0);
      checkBit("post_rst_busy", busy, 1'b0);
      checkBit("post_rst_start", div_start, 1'b0);
    end
    div_done = 1'b0;

    // Normal operation resumes after reset.
    pushOne(randReq());
    runOp({$urandom, $urandom}, 5'h10, 1'b1, 2, 1'b1, 1'b0, 1'b1);
    checkBit("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
